// File: rtl/spi_slave_sync_rx.sv
// spi_slave_sync_rx: SPI slave receive front end.
// Synchronises and debounces the asynchronous sck/ncs/mosi pins into clk.
// Supports every CPOL/CPHA mode and deserialises mosi into WORD_W-bit words.
// Reports frame start, frame abort and busy to the command layer.
// Optional feature macro: SPI_SYNC_MISO_EN adds tx_data/miso/miso_oe and a
// transmit shift register. The default build leaves it out.
//
// Handshake: rx_valid is a one-clk strobe and has no ready. rx_data is valid
// while rx_valid is high. It then holds until the next word completes.
// spi_start and frame_abort are one-clk strobes.
// state_dbg exposes the FSM encoding: 0 IDLE, 1 ACTIVE, 2 TAIL.
module spi_slave_sync_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ncs,
    input  logic              mosi,
`ifdef SPI_SYNC_MISO_EN
    input  logic [WORD_W-1:0] tx_data,
    output logic              miso,
    output logic              miso_oe,
`endif
    output logic              spi_start,
    output logic              spi_busy,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_abort,
    output logic [1:0]        state_dbg
);

    localparam int          CW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic        IDLE_LVL = (CPOL != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TAIL   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] ncs_sync, sck_sync, mosi_sync;
    logic                   ncs_db, sck_db;
    logic                   ncs_db_next, sck_db_next;
    logic                   ncs_fall, ncs_rise;
    logic                   sck_lead, sck_trail, edge_ok;
    logic                   sample_edge, shift_edge;
    logic                   mosi_a;
    logic                   start_set, abort_set;
    logic [CW-1:0]          bit_cnt;
    logic [WORD_W-1:0]      shreg, word_next;

    // Input synchronisers. All three chains have equal depth, so mosi stays
    // aligned with the sck sample that sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync  <= {SYNC_STAGES{1'b1}};
            sck_sync  <= {SYNC_STAGES{IDLE_LVL}};
            mosi_sync <= '0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    // Debounce: a state changes only when every chain stage agrees on the new level.
    always_comb begin
        ncs_db_next = ncs_db;
        sck_db_next = sck_db;
        if (&ncs_sync)
            ncs_db_next = 1'b1;
        else if (~|ncs_sync)
            ncs_db_next = 1'b0;
        if (&sck_sync)
            sck_db_next = 1'b1;
        else if (~|sck_sync)
            sck_db_next = 1'b0;
    end

    // Debounced pin states.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_db <= 1'b1;
            sck_db <= IDLE_LVL;
        end else begin
            ncs_db <= ncs_db_next;
            sck_db <= sck_db_next;
        end
    end

    assign ncs_fall  = ncs_db & ~ncs_db_next;
    assign ncs_rise  = ~ncs_db & ncs_db_next;
    assign sck_lead  = (sck_db == IDLE_LVL) && (sck_db_next != IDLE_LVL);
    assign sck_trail = (sck_db != IDLE_LVL) && (sck_db_next == IDLE_LVL);
    // An sck edge is ignored when ncs is not settled low on both sides of it.
    assign edge_ok     = ~ncs_db & ~ncs_db_next;
    assign sample_edge = edge_ok & ((CPHA != 0) ? sck_trail : sck_lead);
    assign shift_edge  = edge_ok & ((CPHA != 0) ? sck_lead : sck_trail);
    assign mosi_a      = mosi_sync[SYNC_STAGES-1];
    assign state_dbg   = state;

    // Assemble the next word with the new bit entering from the side that
    // matches the bit order.
    always_comb begin
        word_next = shreg;
        if (MSB_FIRST != 0)
            word_next = {shreg[WORD_W-2:0], mosi_a};
        else
            word_next = {mosi_a, shreg[WORD_W-1:1]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state and strobe requests.
    always_comb begin
        state_next = state;
        start_set  = 1'b0;
        abort_set  = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = ACTIVE;
                    start_set  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ncs_rise) begin
                    state_next = TAIL;
                    abort_set  = (bit_cnt != '0);
                end
            end
            TAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Receive datapath and strobes. spi_busy follows ACTIVE one clk late, so
    // it stays high through the TAIL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_start   <= 1'b0;
            spi_busy    <= 1'b0;
            frame_abort <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
        end else begin
            spi_start   <= start_set;
            frame_abort <= abort_set;
            spi_busy    <= (state == ACTIVE);
            rx_valid    <= 1'b0;
            if (start_set) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (state == ACTIVE && sample_edge) begin
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= word_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                end else begin
                    shreg   <= word_next;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

`ifdef SPI_SYNC_MISO_EN
    logic [WORD_W-1:0] tx_sh;

    // Transmit shifter. It reloads at frame start and at each word boundary.
    // It skips the non-sample edge that comes while bit_cnt is 0. For CPHA=0
    // that edge follows a reload. For CPHA=1 it comes before the first sample.
    // Either way, the freshly loaded first bit must stay on miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh <= '0;
        end else if (start_set) begin
            tx_sh <= tx_data;
        end else if (state == ACTIVE && sample_edge && bit_cnt == LAST_BIT) begin
            tx_sh <= tx_data;
        end else if (state == ACTIVE && shift_edge && bit_cnt != '0) begin
            if (MSB_FIRST != 0)
                tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
            else
                tx_sh <= {1'b0, tx_sh[WORD_W-1:1]};
        end
    end

    assign miso    = (MSB_FIRST != 0) ? tx_sh[WORD_W-1] : tx_sh[0];
    assign miso_oe = (state == ACTIVE);
`endif

endmodule

// File: tb/tb_spi_slave_sync_rx.sv
// Directed bench for spi_slave_sync_rx.
// u0: CPOL=0 CPHA=0 MSB first. u1: CPOL=1 CPHA=1 LSB first.
// The SPI_SYNC_MISO_EN build also checks the miso path on u0.
module tb_spi_slave_sync_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sck_p, ncs_p, mosi_p;

    logic       start0, busy0, valid0, abort0;
    logic [7:0] rx0;
    logic [1:0] st0;
    logic       start1, busy1, valid1, abort1;
    logic [7:0] rx1;
    logic [1:0] st1;
`ifdef SPI_SYNC_MISO_EN
    logic [7:0] tx0, tx1;
    logic       miso0, oe0, miso1, oe1;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         nstart0 = 0, nvalid0 = 0, nabort0 = 0;
    int         nstart1 = 0, nvalid1 = 0, nabort1 = 0;
    logic [7:0] got_q0[$];
    logic [7:0] got_q1[$];
    logic [7:0] exp_q[$];
    logic [7:0] miso_rd;

    // Clock.
    always #5 clk = ~clk;

    spi_slave_sync_rx #(.SYNC_STAGES(2), .WORD_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .sck(sck_p[0]), .ncs(ncs_p[0]), .mosi(mosi_p[0]),
`ifdef SPI_SYNC_MISO_EN
        .tx_data(tx0), .miso(miso0), .miso_oe(oe0),
`endif
        .spi_start(start0), .spi_busy(busy0), .rx_data(rx0), .rx_valid(valid0),
        .frame_abort(abort0), .state_dbg(st0)
    );

    spi_slave_sync_rx #(.SYNC_STAGES(2), .WORD_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .sck(sck_p[1]), .ncs(ncs_p[1]), .mosi(mosi_p[1]),
`ifdef SPI_SYNC_MISO_EN
        .tx_data(tx1), .miso(miso1), .miso_oe(oe1),
`endif
        .spi_start(start1), .spi_busy(busy1), .rx_data(rx1), .rx_valid(valid1),
        .frame_abort(abort1), .state_dbg(st1)
    );

    // Strobe monitor: counts the clk cycles each strobe is high and captures received words.
    always @(negedge clk) begin
        if (valid0) begin got_q0.push_back(rx0); nvalid0++; end
        if (valid1) begin got_q1.push_back(rx1); nvalid1++; end
        if (start0) nstart0++;
        if (start1) nstart1++;
        if (abort0) nabort0++;
        if (abort1) nabort1++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_word(input int d, output logic [7:0] w);
        w = 8'hxx;
        if (d == 0 && got_q0.size() > 0) w = got_q0.pop_front();
        if (d == 1 && got_q1.size() > 0) w = got_q1.pop_front();
    endtask

    task automatic frame_begin(input int d);
        ncs_p[d] = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end(input int d);
        wait_clk(5);
        ncs_p[d] = 1'b1;
    endtask

    // Master driver with sck = clk/10. glitch_bit >= 0 adds a 1-clk sck glitch after that bit.
    task automatic send_bits(input int d, input logic [7:0] w, input int nbits, input int glitch_bit);
        logic cpol;
        logic cpha;
        logic msb;
        cpol = (d == 1);
        cpha = (d == 1);
        msb  = (d == 0);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = msb ? w[7-i] : w[i];
            if (!cpha) begin
                mosi_p[d] = b;
                wait_clk(5);
`ifdef SPI_SYNC_MISO_EN
                if (d == 0) miso_rd = {miso_rd[6:0], miso0};
`endif
                sck_p[d] = ~cpol;
                wait_clk(5);
                sck_p[d] = cpol;
            end else begin
                sck_p[d]  = ~cpol;
                mosi_p[d] = b;
                wait_clk(5);
                sck_p[d] = cpol;
                wait_clk(5);
            end
            if (i == glitch_bit) begin
                wait_clk(2);
                sck_p[d] = ~cpol;
                wait_clk(1);
                sck_p[d] = cpol;
                wait_clk(2);
            end
        end
    endtask

    // Directed sequence.
    initial begin
        logic [7:0] w;
        rst     = 1'b1;
        sck_p   = 2'b10;
        ncs_p   = 2'b11;
        mosi_p  = 2'b00;
        miso_rd = 8'h00;
`ifdef SPI_SYNC_MISO_EN
        tx0 = 8'h00;
        tx1 = 8'h00;
`endif
        wait_clk(4);
        check("rst_start0", start0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_valid0", valid0, 0);
        check("rst_abort0", abort0, 0);
        check("rst_rx0", rx0, 0);
        check("rst_state0", st0, 0);
        check("rst_rx1", rx1, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;
        wait_clk(4);
        check("idle_start_cnt0", nstart0, 0);
        check("idle_busy0", busy0, 0);

        // Single word 0xA5 in mode 0, then check the busy tail timing.
        frame_begin(0);
        check("t1_start_cnt", nstart0, 1);
        check("t1_state_active", st0, 1);
        check("t1_busy_mid", busy0, 1);
        send_bits(0, 8'hA5, 8, -1);
        check("t1_valid_cnt", nvalid0, 1);
        check("t1_rx_data", rx0, 8'hA5);
        frame_end(0);
        wait_clk(3);
        check("t1_busy_tail", busy0, 1);
        check("t1_state_tail", st0, 2);
        wait_clk(1);
        check("t1_busy_fall", busy0, 0);
        check("t1_state_idle", st0, 0);
        wait_clk(6);
        check("t1_abort_cnt", nabort0, 0);
        pop_word(0, w);
        check("t1_word", w, 8'hA5);
        check("t1_rx_hold", rx0, 8'hA5);

        // Two back-to-back words in mode 3, LSB first.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        frame_begin(1);
        send_bits(1, 8'h3C, 8, -1);
        send_bits(1, 8'hC3, 8, -1);
        frame_end(1);
        wait_clk(10);
        check("t2_valid_cnt", nvalid1, 2);
        check("t2_start_cnt", nstart1, 1);
        check("t2_abort_cnt", nabort1, 0);
        while (exp_q.size() > 0) begin
            pop_word(1, w);
            check("t2_word", w, exp_q.pop_front());
        end

        // 0x01 LSB first, with a 1-clk sck glitch after bit 3.
        frame_begin(1);
        send_bits(1, 8'h01, 8, 3);
        frame_end(1);
        wait_clk(10);
        check("t3_valid_cnt", nvalid1, 3);
        pop_word(1, w);
        check("t3_word", w, 8'h01);
        check("t3_rx_data", rx1, 8'h01);
        check("t3_abort_cnt", nabort1, 0);

        // ncs rises after 5 bits, then a clean 0x81 frame.
        frame_begin(0);
        send_bits(0, 8'hFF, 5, -1);
        frame_end(0);
        wait_clk(10);
        check("t4_abort_cnt", nabort0, 1);
        check("t4_valid_cnt", nvalid0, 1);
        check("t4_rx_hold", rx0, 8'hA5);
        frame_begin(0);
        send_bits(0, 8'h81, 8, -1);
        frame_end(0);
        wait_clk(10);
        check("t4b_valid_cnt", nvalid0, 2);
        pop_word(0, w);
        check("t4b_word", w, 8'h81);
        check("t4b_abort_cnt", nabort0, 1);

        // Reset in the middle of a word, then a clean 0x5A frame.
        frame_begin(0);
        send_bits(0, 8'hC3, 3, -1);
        rst = 1'b1;
        wait_clk(1);
        check("t5_rst_busy", busy0, 0);
        check("t5_rst_rx", rx0, 0);
        check("t5_rst_valid", valid0, 0);
        check("t5_rst_start", start0, 0);
        check("t5_rst_abort", abort0, 0);
        check("t5_rst_state", st0, 0);
        check("t5_rst_rx1", rx1, 0);
        ncs_p[0] = 1'b1;
        sck_p[0] = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        check("t5_abort_cnt", nabort0, 1);
        check("t5_valid_cnt", nvalid0, 2);
        check("t5_busy_after", busy0, 0);
        frame_begin(0);
        send_bits(0, 8'h5A, 8, -1);
        frame_end(0);
        wait_clk(10);
        check("t5b_valid_cnt", nvalid0, 3);
        pop_word(0, w);
        check("t5b_word", w, 8'h5A);
        check("t5b_start_cnt", nstart0, 5);
        check("t5b_abort_cnt", nabort0, 1);

`ifdef SPI_SYNC_MISO_EN
        // Master reads tx_data on miso while it sends 0xFF.
        tx0 = 8'h96;
        check("t6_oe_idle", oe0, 0);
        frame_begin(0);
        check("t6_oe_active", oe0, 1);
        miso_rd = 8'h00;
        send_bits(0, 8'hFF, 8, -1);
        frame_end(0);
        wait_clk(3);
        check("t6_oe_tail", oe0, 0);
        wait_clk(10);
        check("t6_miso_word", miso_rd, 8'h96);
        check("t6_rx_data", rx0, 8'hFF);
        check("t6_oe_after", oe0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
